// File: rtl/energy_cal_pkg.sv
// Shared widths, coefficient-word field positions and saturation helpers
// for the per-photon energy calibration stage.
package energy_cal_pkg;
   localparam int CH_W   = 10;
   localparam int PH_W   = 16;
   localparam int E_W    = 24;
   localparam int ACC_W  = 28;
   localparam int FRAC   = 13;
   localparam int SQ_W   = 19;
   localparam int WORD_W = 64;

   // coefficient word: [63:48] c2, [47:24] c1, [23:0] c0, all signed
   localparam int C2_W   = 16;
   localparam int C2_LSB = 48;
   localparam int C1_W   = 24;
   localparam int C1_LSB = 24;
   localparam int C0_W   = 24;
   localparam int C0_LSB = 0;

   // accumulator does not fit in E_W signed bits
   function automatic logic acc_ovf(input logic signed [ACC_W-1:0] a);
      return !((&a[ACC_W-1:E_W-1]) || !(|a[ACC_W-1:E_W-1]));
   endfunction

   // clamp accumulator to the signed 24-bit energy range
   function automatic logic signed [E_W-1:0] sat24(input logic signed [ACC_W-1:0] a);
      if (!acc_ovf(a))       return a[E_W-1:0];
      else if (a[ACC_W-1])   return {1'b1, {(E_W-1){1'b0}}};
      else                   return {1'b0, {(E_W-1){1'b1}}};
   endfunction
endpackage

// File: rtl/energy_cal_delay.sv
// Fixed-depth alignment shift register: a valid lane that is cleared by
// reset and an unreset data lane that simply follows along.
module energy_cal_delay #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vld_in,
   input  logic [W-1:0] d,
   output logic         vld_out,
   output logic [W-1:0] q
);
   logic [DEPTH-1:0]         vld_pipe;
   logic [DEPTH-1:0][W-1:0]  dat_pipe;

   // valid lane: in-flight events vanish on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else begin
         vld_pipe[0] <= vld_in;
         for (int k = 1; k < DEPTH; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   // data lane: no reset, outputs are qualified by the valid lane
   always_ff @(posedge clk) begin
      dat_pipe[0] <= d;
      for (int k = 1; k < DEPTH; k++) dat_pipe[k] <= dat_pipe[k-1];
   end

   assign vld_out = vld_pipe[DEPTH-1];
   assign q       = dat_pipe[DEPTH-1];
endmodule

// File: rtl/energy_cal_apply.sv
// Per-photon energy calibration: LUT lookup by channel, quadratic
// c2*ph^2 + c1*ph + c0 in fix_x_13, saturated to 24 bits, fixed latency.
module energy_cal_apply
   import energy_cal_pkg::*;
#(
   parameter int RAM_LAT = 3,
   parameter int SB_W    = 36
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [CH_W-1:0]     in_ch,
   input  logic [PH_W-1:0]     in_ph,
   input  logic [SB_W-1:0]     in_sb,
   output logic                bram_en_a,
   output logic [CH_W-1:0]     bram_addr,
   output logic                bram_we,
   output logic [WORD_W-1:0]   bram_wr_data,
   input  logic [WORD_W-1:0]   bram_rd_data,
   output logic                out_valid,
   output logic [E_W-1:0]      out_energy,
   output logic                out_nocal,
   output logic [SB_W-1:0]     out_sb,
   input  logic                sat_clr,
   output logic [15:0]         sat_count
);
   localparam int P1_W  = C1_W + PH_W;   // c1*ph
   localparam int SQP_W = 2 * PH_W;      // ph*ph
   localparam int P2_W  = C2_W + SQ_W;   // c2*sq
   localparam int T1_W  = P1_W - FRAC;
   localparam int T2_W  = P2_W - FRAC;
   localparam int D1_W  = SB_W + SQ_W + PH_W;

   logic signed [PH_W-1:0]  ph_a, ph_rd;
   logic [SB_W-1:0]         sb_a, sb_rd, sb_m3;
   logic signed [SQ_W-1:0]  sq_a, sq_rd, sq_m1;
   logic                    v_rd, v_m3, nocal_rd, nocal_m3;
   logic signed [C2_W-1:0]  c2_rd, c2_m1;
   logic signed [C1_W-1:0]  c1_rd;
   logic signed [C0_W-1:0]  c0_rd, c0_m1, c0_m2;
   logic signed [P1_W-1:0]  p1;
   logic signed [T1_W-1:0]  t1;
   logic signed [T2_W-1:0]  t2;
   logic signed [ACC_W-1:0] acc;

   assign bram_we      = 1'b0;
   assign bram_wr_data = '0;

   // stage A: present the LUT read, capture the event payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram_en_a <= 1'b0;
         bram_addr <= '0;
         ph_a      <= '0;
         sb_a      <= '0;
      end else begin
         bram_en_a <= in_valid;
         bram_addr <= in_ch;
         ph_a      <= in_ph;
         sb_a      <= in_sb;
      end
   end

   // squared term is formed while the RAM read is outstanding
   assign sq_a = SQ_W'((SQP_W'(ph_a) * SQP_W'(ph_a)) >>> FRAC);

   // hold ph/sq/sideband until the coefficient word returns
   energy_cal_delay #(.W(D1_W), .DEPTH(RAM_LAT)) u_dly_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld_in  (bram_en_a),
      .d       ({sb_a, sq_a, ph_a}),
      .vld_out (v_rd),
      .q       ({sb_rd, sq_rd, ph_rd})
   );

   assign c2_rd    = bram_rd_data[C2_LSB +: C2_W];
   assign c1_rd    = bram_rd_data[C1_LSB +: C1_W];
   assign c0_rd    = bram_rd_data[C0_LSB +: C0_W];
   assign nocal_rd = (bram_rd_data == '0);

   // carry valid, nocal and sideband through M1..M3
   energy_cal_delay #(.W(SB_W + 1), .DEPTH(3)) u_dly_m (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld_in  (v_rd),
      .d       ({sb_rd, nocal_rd}),
      .vld_out (v_m3),
      .q       ({sb_m3, nocal_m3})
   );

   // M1..M3 datapath: multiply, rescale by 2^-13, sum
   always_ff @(posedge clk) begin
      p1    <= P1_W'(c1_rd) * P1_W'(ph_rd);
      c2_m1 <= c2_rd;
      c0_m1 <= c0_rd;
      sq_m1 <= sq_rd;
      t1    <= T1_W'(p1 >>> FRAC);
      t2    <= T2_W'((P2_W'(c2_m1) * P2_W'(sq_m1)) >>> FRAC);
      c0_m2 <= c0_m1;
      acc   <= ACC_W'(c0_m2) + ACC_W'(t1) + ACC_W'(t2);
   end

   // M4: output register, data forced to zero outside valid slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_energy <= '0;
         out_nocal  <= 1'b0;
         out_sb     <= '0;
      end else begin
         out_valid  <= v_m3;
         out_energy <= (v_m3 && !nocal_m3) ? sat24(acc) : '0;
         out_nocal  <= v_m3 && nocal_m3;
         out_sb     <= v_m3 ? sb_m3 : '0;
      end
   end

   // saturation counter: clear wins, sticks at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   sat_count <= '0;
      else if (sat_clr)             sat_count <= '0;
      else if (v_m3 && acc_ovf(acc) && sat_count != 16'hFFFF)
                                    sat_count <= sat_count + 16'd1;
   end
endmodule

// File: tb/tb_energy_cal_apply.sv
// Bench for energy_cal_apply: directed cases plus random traffic, checked
// against an integer reference model with a time-stamped expectation queue.
module tb_energy_cal_apply;
   localparam int RAM_LAT = 3;
   localparam int SB_W    = 36;
   localparam int LAT     = RAM_LAT + 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [9:0]        in_ch = '0;
   logic [15:0]       in_ph = '0;
   logic [SB_W-1:0]   in_sb = '0;
   logic              bram_en_a, bram_we;
   logic [9:0]        bram_addr;
   logic [63:0]       bram_wr_data, bram_rd_data;
   logic              out_valid, out_nocal;
   logic [23:0]       out_energy;
   logic [SB_W-1:0]   out_sb;
   logic              sat_clr = 1'b0;
   logic [15:0]       sat_count;

   typedef struct {
      int              cyc;
      longint          e;
      bit              nc;
      bit              sat;
      logic [SB_W-1:0] sb;
   } exp_t;

   exp_t   q[$];
   exp_t   mx;
   int     cyc = 0;
   int     n_chk = 0;
   int     n_err = 0;
   int     m_sat = 0;
   logic   clr_smp = 1'b0;
   logic [63:0] mem [1024];
   logic [RAM_LAT-1:0][63:0] rd_p;

   always #5 clk = ~clk;

   energy_cal_apply #(.RAM_LAT(RAM_LAT), .SB_W(SB_W)) dut (
      .clk (clk), .rst_n (rst_n),
      .in_valid (in_valid), .in_ch (in_ch), .in_ph (in_ph), .in_sb (in_sb),
      .bram_en_a (bram_en_a), .bram_addr (bram_addr), .bram_we (bram_we),
      .bram_wr_data (bram_wr_data), .bram_rd_data (bram_rd_data),
      .out_valid (out_valid), .out_energy (out_energy), .out_nocal (out_nocal),
      .out_sb (out_sb), .sat_clr (sat_clr), .sat_count (sat_count)
   );

   // port-A model: RAM_LAT cycles from address to data
   always @(posedge clk) begin
      if (bram_en_a) rd_p[0] <= mem[bram_addr];
      for (int i = 1; i < RAM_LAT; i++) rd_p[i] <= rd_p[i-1];
   end
   assign bram_rd_data = rd_p[RAM_LAT-1];

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      clr_smp <= sat_clr;
   end

   task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] word(input logic [15:0] c2, input logic [23:0] c1, input logic [23:0] c0);
      return {c2, c1, c0};
   endfunction

   // reference: energy = c0 + (c1*ph >>> 13) + (c2*((ph*ph) >>> 13) >>> 13), clamped
   function automatic void model(input logic [63:0] w, input logic [15:0] ph, output longint e, output bit sat);
      longint c2, c1, c0, p, sq, acc;
      c2  = longint'($signed(w[63:48]));
      c1  = longint'($signed(w[47:24]));
      c0  = longint'($signed(w[23:0]));
      p   = longint'($signed(ph));
      sq  = (p * p) >>> 13;
      acc = c0 + ((c1 * p) >>> 13) + ((c2 * sq) >>> 13);
      sat = (acc > 8388607) || (acc < -8388608);
      e   = (acc > 8388607) ? 8388607 : ((acc < -8388608) ? -8388608 : acc);
      if (w == 64'd0) e = 0;
   endfunction

   task automatic drive(input bit v, input int ch, input logic [15:0] ph, input logic [SB_W-1:0] sb, input bit clr);
      exp_t x;
      @(posedge clk); #1;
      in_valid = v; in_ch = 10'(ch); in_ph = ph; in_sb = sb; sat_clr = clr;
      if (v) begin
         model(mem[ch], ph, x.e, x.sat);
         x.nc  = (mem[ch] == 64'd0);
         x.sb  = sb;
         x.cyc = cyc + LAT + 1;
         q.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 16'h0, '0, 0);
   endtask

   function automatic logic [SB_W-1:0] rsb();
      return SB_W'({$urandom, $urandom});
   endfunction

   // cycle-accurate output checking against the expectation queue
   always @(negedge clk) begin
      if (!rst_n || clr_smp) m_sat = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         mx = q.pop_front();
         chk("valid",  out_valid, 1);
         chk("energy", $signed(out_energy), mx.e);
         chk("nocal",  out_nocal, mx.nc);
         chk("sb",     out_sb, mx.sb);
         if (rst_n && !clr_smp && mx.sat && m_sat < 65535) m_sat++;
      end else begin
         chk("idle_valid", out_valid, 0);
      end
      chk("sat_count", sat_count, m_sat);
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid",  out_valid, 0);
      chk("rst_out_energy", out_energy, 0);
      chk("rst_out_nocal",  out_nocal, 0);
      chk("rst_out_sb",     out_sb, 0);
      chk("rst_en_a",       bram_en_a, 0);
      chk("rst_addr",       bram_addr, 0);
      chk("rst_sat_count",  sat_count, 0);
      chk("bram_we",        bram_we, 0);
      chk("bram_wr_data",   bram_wr_data, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      mem[5] = word(16'd0, 24'd8192, 24'd100);
      mem[6] = word(16'd2, 24'd8192, 24'd100);
      mem[7] = word(16'd0, 24'd8192, 24'h7FFFFF);
      mem[9] = 64'd0;
      for (int i = 0; i < 4; i++) mem[i] = word(16'd0, 24'd0, 24'(10 * (i + 1)));

      // unity gain, quadratic term +/-1.0
      drive(1, 5, 16'h2000, rsb(), 0);
      idle(9);
      drive(1, 6, 16'h2000, rsb(), 0);
      drive(1, 6, 16'hE000, rsb(), 0);
      idle(9);
      // saturation, then a second one coinciding with sat_clr
      drive(1, 7, 16'h2000, rsb(), 0);
      idle(9);
      drive(1, 7, 16'h2000, rsb(), 0);
      idle(6);
      drive(0, 0, 16'h0, '0, 1);
      idle(3);
      // uncalibrated channel
      drive(1, 9, 16'h1234, rsb(), 0);
      idle(2);
      // back-to-back
      for (int i = 0; i < 4; i++) drive(1, i, 16'($urandom), rsb(), 0);
      idle(10);

      // reset while three events are in flight
      drive(1, 5, 16'h2000, rsb(), 0);
      drive(1, 6, 16'hE000, rsb(), 0);
      drive(1, 0, 16'h2000, rsb(), 0);
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0; q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("flush_valid",  out_valid, 0);
         chk("flush_energy", out_energy, 0);
         chk("flush_nocal",  out_nocal, 0);
         chk("flush_sb",     out_sb, 0);
      end
      drive(1, 5, 16'h2000, rsb(), 0);
      idle(10);

      // random traffic over 16 channels with mixed coefficient words
      for (int i = 0; i < 16; i++) begin
         case ($urandom % 4)
            0:       mem[i] = 64'd0;
            1:       mem[i] = {$urandom, $urandom};
            2:       mem[i] = word(16'($urandom_range(0, 64)) - 16'd32, 24'($urandom_range(4096, 12288)), 24'($urandom_range(0, 4000)));
            default: mem[i] = word(16'($urandom), 24'h7FFFFF, 24'h7FFF00);
         endcase
      end
      for (int i = 0; i < 400; i++)
         drive(($urandom % 10) < 7, int'($urandom % 16), 16'($urandom), rsb(), ($urandom % 20) == 0);
      idle(12);

      chk("drain", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/energy_cal_apply.md
# energy_cal_apply

Per-photon energy calibration stage in the wavelength capture path. It takes phase-height photon events, uses the resonator channel to read that channel's 64-bit quadratic coefficient word from the energy-coefficient LUT BRAM (port A, 1024 x 64), and emits a saturated 24-bit signed energy with the event's sideband. It is a fully pipelined, one-event-per-cycle stage between the photon trigger and the capture packetiser, with no backpressure.

## Interface
- RAM_LAT, 3, BRAM port-A read latency in cycles from the cycle `bram_addr` is presented to the cycle `bram_rd_data` is valid
- SB_W, 36, width of the pass-through sideband (timestamp and flags)
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous assert, active-low (one clock; asynchronous active-low reset, as decided)
- in_valid  in  1  event strobe, any cycle, back-to-back allowed
- in_ch  in  10  resonator channel, the LUT address
- in_ph  in  16  phase height, signed fix_16_13
- in_sb  in  SB_W  sideband, delayed unchanged
- bram_en_a  out  1  LUT read enable
- bram_addr  out  10  LUT address
- bram_we  out  1  tied 0
- bram_wr_data  out  64  tied 0
- bram_rd_data  in  64  coefficient word: [63:48] c2 s16, [47:24] c1 s24, [23:0] c0 s24
- out_valid  out  1  result strobe
- out_energy  out  24  signed energy, saturated
- out_nocal  out  1  coefficient word was all zero
- out_sb  out  SB_W  delayed sideband
- sat_clr  in  1  synchronous clear of sat_count
- sat_count  out  16  saturation event counter, sticks at 0xFFFF

## Operation
- Stage A (edge 1): register `in_ch` to `bram_addr`, and `in_valid` to `bram_en_a`. Also register `ph` and `sb`.
- Squared term: `sq = (ph*ph) >>> 13`, held as 19-bit signed. It is computed during the RAM wait and delayed to line up with M2.
- M1, when `bram_rd_data` is valid:
  - `p1 = c1*ph` (40-bit signed).
  - Latch `c2` and `c0`.
  - `nocal = (word == 0)`.
- M2:
  - `t1 = p1 >>> 13` (27 bits).
  - `t2 = (c2*sq) >>> 13` (35-bit product, 22-bit result).
- M3: `acc = sext28(c0) + sext28(t1) + sext28(t2)`.
- M4, output register:
  - `out_energy = sat24(acc)`: clamp to 0x7FFFFF or 0x800000.
  - `out_valid = valid`.
  - `out_nocal`, `out_sb`.
- All shifts are arithmetic and truncate toward -inf. There is no rounding.
- The `nocal` event still produces `out_valid`, with `out_energy` = 0.
- `sat_count` increments on each valid M4 result that clamps, and sticks at 0xFFFF.
- If `sat_clr` and a saturation occur in the same cycle, the clear wins: the count goes to 0 and that event is not counted.
- Data registers do not need enables. Only the valid chain gates outputs and the counter.

## Timing
- Latency: `out_valid` is asserted exactly RAM_LAT+4 rising edges after the edge that samples `in_valid` (7 at the default).
- Throughput is 1 event/cycle. Output order equals input order. There are no stalls and no drops.
- Reset (async, `rst_n` low) clears the whole valid chain, `bram_en_a`, `bram_addr`, `out_valid`, `out_energy`, `out_nocal`, `out_sb` and `sat_count` to 0.
- Reset mid-flight discards every in-flight event. No `out_valid` occurs until a new `in_valid` arrives after `rst_n` rises, and that event appears RAM_LAT+4 cycles later.
- The LUT may be rewritten via port B at any time. An event uses whichever word the BRAM returns for its read. There is no coherency guarantee.

## Structure
- Package `energy_cal_pkg` holds:
  - widths: CH_W=10, PH_W=16, E_W=24, ACC_W=28
  - the bit slices of the c2/c1/c0 fields
  - FRAC=13
  - function `sat24`
- Sub-module `energy_cal_delay`: a parameterised-width, parameterised-depth shift register with reset on the valid bit only. It is used for the valid, `ph`/`sq`, `nocal` and sideband alignment.
- The top level holds the multiply/add stages and the counter.

## Test plan
- Unity gain, default RAM_LAT=3: ch 5 = {c2=0, c1=8192, c0=100}, ph=0x2000 -> `out_energy`=8292 at cycle 7, `out_nocal`=0, `out_sb` echoed.
- Quadratic term: ch 6 = {c2=2, c1=8192, c0=100}, ph=0x2000 -> 8294. Same word with ph=0xE000 (-1.0) -> -8092 + 2 = -8090.
- Saturation: {c2=0, c1=8192, c0=0x7FFFFF}, ph=0x2000 -> `out_energy`=0x7FFFFF and `sat_count`=1. Assert `sat_clr` on the same cycle as a second saturating result -> `sat_count`=0.
- No cal: ch 9 word = 0 -> `out_valid`=1, `out_nocal`=1, `out_energy`=0.
- Back-to-back: ch 0..3 on 4 consecutive cycles with c0=10,20,30,40 and c1=c2=0 -> `out_valid` high at cycles 7-10 with energies 10,20,30,40 in order.
- Reset mid-flight: inject 3 events, pull `rst_n` low for 1 cycle at cycle 4 -> no `out_valid` ever, all outputs 0. An event injected after release emerges 7 cycles later.
